// File: rtl/costas_lock_detect_pkg.sv
// Shared types for the Costas lock detector: lock FSM state encoding,
// default sample width and a 3-bit saturating increment.
package costas_lock_detect_pkg;

    typedef enum logic [1:0] {
        UNLK = 2'd0,
        ACQ  = 2'd1,
        LCK  = 2'd2,
        HOLD = 2'd3
    } lock_state_t;

    localparam int DW_DEF = 26;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    function automatic logic is_locked(input lock_state_t s);
        return (s == LCK) || (s == HOLD);
    endfunction

endpackage

// File: rtl/costas_lock_detect_abs_sat.sv
// Registered saturating magnitude: the most negative code maps to the
// largest positive magnitude so the result always fits in W-1 bits.
module costas_abs_sat #(
    parameter int W = 26
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] x,
    output logic        [W-2:0] y
);

    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] neg;
    assign neg = -x;

    always_ff @(posedge clk) begin
        if (!rst_n)
            y <= '0;
        else if (x == MIN_V)
            y <= '1;
        else if (x[W-1])
            y <= neg[W-2:0];
        else
            y <= x[W-2:0];
    end

endmodule

// File: rtl/costas_lock_detect.sv
// Costas loop lock detector: windowed sum(|I|-|Q|) and sum|I| with a
// hysteresis FSM. Define COSTAS_LOCK_STATS_EN to add the loss_cnt port.
module costas_lock_detect
    import costas_lock_detect_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int WIN_LOG2  = 8,
    parameter int THR_SHIFT = 1,
    parameter int MIN_AMP   = 4096,
    parameter int LOCK_WIN  = 4,
    parameter int LOSS_WIN  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [DW-1:0]          i_in,
    input  logic signed [DW-1:0]          q_in,
    output logic signed [DW+WIN_LOG2:0]   metric,
    output logic                          metric_valid,
    output logic                          lock,
`ifdef COSTAS_LOCK_STATS_EN
    output logic [15:0]                   loss_cnt,
`endif
    output logic                          lock_chg
);

    localparam int AW = DW + WIN_LOG2 + 1;
    localparam logic signed [AW-1:0] MIN_AMP_V = AW'(MIN_AMP);
    localparam logic [2:0] LOCK_W3 = 3'(LOCK_WIN);
    localparam logic [2:0] LOSS_W3 = 3'(LOSS_WIN);

    logic [DW-2:0] a_i, a_q;
    logic          vld_s1;

    costas_abs_sat #(.W(DW)) u_abs_i (.clk(clk), .rst_n(rst_n), .x(i_in), .y(a_i));
    costas_abs_sat #(.W(DW)) u_abs_q (.clk(clk), .rst_n(rst_n), .x(q_in), .y(a_q));

    always_ff @(posedge clk) begin
        if (!rst_n) vld_s1 <= 1'b0;
        else        vld_s1 <= in_valid;
    end

    logic signed [DW-1:0] d;
    logic signed [AW-1:0] acc_d, acc_i, acc_d_nxt, acc_i_nxt;
    logic [WIN_LOG2-1:0]  cnt;
    logic                 good;

    assign d         = $signed({1'b0, a_i}) - $signed({1'b0, a_q});
    assign acc_d_nxt = acc_d + {{(AW-DW){d[DW-1]}}, d};
    assign acc_i_nxt = acc_i + {{(AW-DW+1){1'b0}}, a_i};
    // Judged on the sums including the closing sample, so the FSM moves with metric_valid.
    assign good      = (acc_d_nxt > (acc_i_nxt >>> THR_SHIFT)) && (acc_i_nxt >= MIN_AMP_V);

    lock_state_t state, st_nxt;
    logic [2:0]  gcnt, bcnt, gcnt_nxt, bcnt_nxt;

    always_comb begin
        st_nxt   = state;
        gcnt_nxt = gcnt;
        bcnt_nxt = bcnt;
        case (state)
            UNLK: if (good) begin
                if (LOCK_WIN == 1) st_nxt = LCK;
                else begin st_nxt = ACQ; gcnt_nxt = 3'd1; end
            end
            ACQ: if (good) begin
                if (sat_inc3(gcnt) == LOCK_W3) begin st_nxt = LCK; gcnt_nxt = 3'd0; end
                else gcnt_nxt = sat_inc3(gcnt);
            end else begin
                st_nxt = UNLK; gcnt_nxt = 3'd0;
            end
            LCK: if (!good) begin
                if (LOSS_WIN == 1) st_nxt = UNLK;
                else begin st_nxt = HOLD; bcnt_nxt = 3'd1; end
            end
            HOLD: if (good) begin
                st_nxt = LCK; bcnt_nxt = 3'd0;
            end else if (sat_inc3(bcnt) == LOSS_W3) begin
                st_nxt = UNLK; bcnt_nxt = 3'd0;
            end else begin
                bcnt_nxt = sat_inc3(bcnt);
            end
            default: st_nxt = UNLK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_d        <= '0;
            acc_i        <= '0;
            cnt          <= '0;
            metric       <= '0;
            metric_valid <= 1'b0;
            lock         <= 1'b0;
            lock_chg     <= 1'b0;
            state        <= UNLK;
            gcnt         <= 3'd0;
            bcnt         <= 3'd0;
`ifdef COSTAS_LOCK_STATS_EN
            loss_cnt     <= '0;
`endif
        end else begin
            metric_valid <= 1'b0;
            lock_chg     <= 1'b0;
            if (vld_s1) begin
                cnt <= cnt + 1'b1;
                if (cnt == '1) begin
                    acc_d        <= '0;
                    acc_i        <= '0;
                    metric       <= acc_d_nxt;
                    metric_valid <= 1'b1;
                    state        <= st_nxt;
                    gcnt         <= gcnt_nxt;
                    bcnt         <= bcnt_nxt;
                    lock         <= is_locked(st_nxt);
                    lock_chg     <= is_locked(st_nxt) != lock;
`ifdef COSTAS_LOCK_STATS_EN
                    if (is_locked(state) && st_nxt == UNLK && loss_cnt != 16'hFFFF)
                        loss_cnt <= loss_cnt + 16'd1;
`endif
                end else begin
                    acc_d <= acc_d_nxt;
                    acc_i <= acc_i_nxt;
                end
            end
        end
    end

endmodule
